// File: rtl/score_display_ctrl_pkg.sv
// Shared types and sizes for the seven-segment score display.
package display_pkg;
    typedef enum logic {IDLE, CONVERT} disp_state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BIN_W      = 14;
    localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
    localparam logic [BIN_W-1:0] MAX_SCORE = 14'd9999;
endpackage

// File: rtl/score_display_ctrl_bin_to_bcd.sv
// Sequential double-dabble: one add-3/shift step per cycle, BIN_W cycles per conversion.
module bin_to_bcd
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             start_i,
    input  logic [BIN_W-1:0] value_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);
    disp_state_t      state_q;
    logic [3:0]       cnt_q;
    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q, bcd_adj, bcd_d;

    always_comb begin
        bcd_adj = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            bcd_adj[k*4 +: 4] = (bcd_q[k*4 +: 4] >= 4'd5) ? bcd_q[k*4 +: 4] + 4'd3
                                                          : bcd_q[k*4 +: 4];
        end
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    bin_q   <= (value_i > MAX_SCORE) ? MAX_SCORE : value_i;
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= CONVERT;
                end
                CONVERT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + 4'd1;
                    if (done_o) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // done and bcd_o describe the step being taken this cycle, so the caller
    // can commit the final result on the same edge as the last shift.
    assign busy_o = (state_q == CONVERT);
    assign done_o = busy_o && (cnt_q == 4'(BIN_W - 1));
    assign bcd_o  = bcd_d;
endmodule

// File: rtl/ssdec.sv
// Seven-segment decoder, segments {g,f,e,d,c,b,a} active high; dark when disabled.
module ssdec (
    input  logic [3:0] in,
    input  logic       enable,
    output logic [6:0] out
);
    always_comb begin
        out = 7'b0000000;
        if (enable) begin
            case (in)
                4'd0:    out = 7'b0111111;
                4'd1:    out = 7'b0000110;
                4'd2:    out = 7'b1011011;
                4'd3:    out = 7'b1001111;
                4'd4:    out = 7'b1100110;
                4'd5:    out = 7'b1101101;
                4'd6:    out = 7'b1111101;
                4'd7:    out = 7'b0000111;
                4'd8:    out = 7'b1111111;
                4'd9:    out = 7'b1101111;
                default: out = 7'b0000000;
            endcase
        end
    end
endmodule

// File: rtl/score_display_ctrl.sv
// Four-digit multiplexed score display: BCD conversion, digit scan, leading-zero blanking.
module score_display_ctrl
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [BIN_W-1:0]      value_i,
    input  logic                  load_i,
    input  logic                  blank_lz_i,
    output logic                  busy_o,
    output logic [NUM_DIGITS-1:0] digit_en_o,
    output logic [6:0]            seg_o
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd, disp_q;
    logic [15:0]      scan_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       nib;
    logic [NUM_DIGITS-1:0] hi_zero;
    logic             blank;

    bin_to_bcd u_conv (
        .clk     (clk),
        .nrst    (nrst),
        .start_i (load_i),
        .value_i (value_i),
        .busy_o  (busy_o),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            disp_q <= '0;
            scan_q <= '0;
            idx_q  <= '0;
        end else begin
            if (conv_done) disp_q <= conv_bcd;
            if (scan_q == 16'(SCAN_DIV - 1)) begin
                scan_q <= '0;
                idx_q  <= idx_q + 1'b1;
            end else begin
                scan_q <= scan_q + 16'd1;
            end
        end
    end

    // hi_zero[k]: nibble k and every nibble above it are zero.
    always_comb begin
        hi_zero = '0;
        hi_zero[NUM_DIGITS-1] = (disp_q[BCD_W-4 +: 4] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            hi_zero[k] = hi_zero[k+1] && (disp_q[k*4 +: 4] == 4'd0);
        end
    end

    assign nib        = disp_q[idx_q*4 +: 4];
    assign blank      = blank_lz_i && (idx_q != '0) && hi_zero[idx_q];
    assign digit_en_o = NUM_DIGITS'(1) << idx_q;

    ssdec u_dec (
        .in     (nib),
        .enable (!blank),
        .out    (seg_o)
    );
endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench: loads push expected busy length and digit patterns, a monitor checks them.
module tb_score_display_ctrl;
    typedef struct {
        string            name;
        int               busy_cycles;
        logic [3:0][6:0]  seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic [13:0] value_i;
    logic        load_i;
    logic        blank_lz_i;
    logic        busy_o;
    logic [3:0]  digit_en_o;
    logic [6:0]  seg_o;

    int n_cmp = 0;
    int n_err = 0;
    exp_t exp_q[$];
    bit   mon_active = 0;

    localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                           S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101,
                           S9 = 7'b1101111, SOFF = 7'b0000000;

    score_display_ctrl #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .value_i    (value_i),
        .load_i     (load_i),
        .blank_lz_i (blank_lz_i),
        .busy_o     (busy_o),
        .digit_en_o (digit_en_o),
        .seg_o      (seg_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // One sample: selected digit's segments against the expected pattern.
    task automatic check_seg(input string nm, input logic [3:0][6:0] e);
        int idx;
        case (digit_en_o)
            4'b0001: idx = 0;
            4'b0010: idx = 1;
            4'b0100: idx = 2;
            4'b1000: idx = 3;
            default: idx = -1;
        endcase
        if (idx < 0) check({nm, " digit_en onehot"}, 32'(digit_en_o), 32'h1);
        else         check($sformatf("%s seg d%0d", nm, idx), 32'(seg_o), 32'(e[idx]));
    endtask

    task automatic check_frame(input string nm, input logic [3:0][6:0] e);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_seg(nm, e);
        end
    endtask

    // Monitor: measure each busy pulse, then check one full refresh of the digits.
    initial begin
        int   bcnt = 0;
        int   win  = 0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                bcnt = 0; win = 0; mon_active = 0;
            end else if (win > 0) begin
                check_seg(cur.name, cur.seg);
                win--;
                if (win == 0) mon_active = 0;
            end else if (busy_o) begin
                bcnt++;
            end else if (bcnt > 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected conversion", 32'(bcnt), 32'h0);
                end else begin
                    cur = exp_q.pop_front();
                    check({cur.name, " busy cycles"}, 32'(bcnt), 32'(cur.busy_cycles));
                    mon_active = 1;
                    check_seg(cur.name, cur.seg);
                    win = 15;
                end
                bcnt = 0;
            end
        end
    end

    task automatic load(input logic [13:0] v);
        @(negedge clk);
        value_i = v;
        load_i  = 1'b1;
        @(negedge clk);
        load_i  = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({nm, " timeout"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        nrst = 1'b0; value_i = '0; load_i = 1'b0; blank_lz_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy_o), 32'h0);
        check("reset digit_en", 32'(digit_en_o), 32'h1);
        check("reset seg", 32'(seg_o), 32'(S0));
        nrst = 1'b1;

        // Scan sequencing after release
        repeat (4) @(negedge clk);
        check("scan 4", 32'(digit_en_o), 32'h2);
        repeat (8) @(negedge clk);
        check("scan 12", 32'(digit_en_o), 32'h8);
        repeat (4) @(negedge clk);
        check("scan 16", 32'(digit_en_o), 32'h1);

        exp_q.push_back('{"load1234", 14, {S1, S2, S3, S4}});
        load(14'd1234);
        wait_idle("load1234");

        exp_q.push_back('{"sat12000", 14, {S9, S9, S9, S9}});
        load(14'd12000);
        wait_idle("sat12000");

        blank_lz_i = 1'b1;
        exp_q.push_back('{"blank5", 14, {SOFF, SOFF, SOFF, S5}});
        load(14'd5);
        wait_idle("blank5");
        blank_lz_i = 1'b0;
        check_frame("noblank5", {S0, S0, S0, S5});

        // Second load lands mid-conversion and must be dropped
        exp_q.push_back('{"dropload", 14, {S1, S2, S3, S4}});
        load(14'd1234);
        repeat (3) @(negedge clk);
        value_i = 14'd42; load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        wait_idle("dropload");

        // Reset mid-conversion
        load(14'd8888);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        check("async rst busy", 32'(busy_o), 32'h0);
        check("async rst digit_en", 32'(digit_en_o), 32'h1);
        check("async rst seg", 32'(seg_o), 32'(S0));
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        check_frame("after rst", {S0, S0, S0, S0});
        repeat (20) @(negedge clk);
        check("leftover expectations", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: sim did not finish, expected finish before 200000");
        $fatal(1);
    end
endmodule
